// File: rtl/rv32i_decoder.sv
// Registered RV32I decode stage: slices the instruction fields, builds the
// sign-extended immediate and flags opcodes outside the base set, one cycle late.
module rv32i_decoder #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [31:0]     inst,
    output logic            out_valid,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpMiscMem = 7'b0001111;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef enum logic [2:0] {
        FmtR,
        FmtI,
        FmtS,
        FmtB,
        FmtU,
        FmtJ,
        FmtNone
    } fmt_e;

    fmt_e            fmt;
    logic [XLEN-1:0] imm_d, imm_q;
    logic            illegal_d, illegal_q;
    logic            out_valid_q;
    logic [6:0]      opcode_q, funct7_q;
    logic [4:0]      rd_q, rs1_q, rs2_q;
    logic [2:0]      funct3_q;

    always_comb begin
        fmt = FmtNone;
        case (inst[6:0])
            OpLoad, OpImm, OpJalr, OpMiscMem, OpSystem: fmt = FmtI;
            OpStore:                                    fmt = FmtS;
            OpBranch:                                   fmt = FmtB;
            OpLui, OpAuipc:                             fmt = FmtU;
            OpJal:                                      fmt = FmtJ;
            OpOp:                                       fmt = FmtR;
            default:                                    fmt = FmtNone;
        endcase
    end

    // inst[31] is the sign bit for every format that sign-extends.
    always_comb begin
        imm_d = '0;
        unique case (fmt)
            FmtI: imm_d = {{(XLEN-12){inst[31]}}, inst[31:20]};
            FmtS: imm_d = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            FmtB: imm_d = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25],
                           inst[11:8], 1'b0};
            FmtU: imm_d = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
            FmtJ: imm_d = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20],
                           inst[30:21], 1'b0};
            FmtR, FmtNone: imm_d = '0;
            default: imm_d = '0;
        endcase
    end

    assign illegal_d = in_valid && (fmt == FmtNone);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            rd_q        <= '0;
            funct3_q    <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            funct7_q    <= '0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
        end else begin
            // Fields are captured even when in_valid is low; only the flags are qualified.
            out_valid_q <= in_valid;
            opcode_q    <= inst[6:0];
            rd_q        <= inst[11:7];
            funct3_q    <= inst[14:12];
            rs1_q       <= inst[19:15];
            rs2_q       <= inst[24:20];
            funct7_q    <= inst[31:25];
            imm_q       <= imm_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign opcode    = opcode_q;
    assign rd        = rd_q;
    assign funct3    = funct3_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign funct7    = funct7_q;
    assign imm       = imm_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_rv32i_decoder.sv
// Self-checking bench for rv32i_decoder: directed encodings, async reset and
// randomized instructions against an arithmetic reference model.
module tb_rv32i_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inst = '0;
    logic        out_valid;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    rv32i_decoder #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inst      (inst),
        .out_valid (out_valid),
        .opcode    (opcode),
        .rd        (rd),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct7    (funct7),
        .imm       (imm),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Immediate as a signed integer value, truncated to 32 bits at the end.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        longint v;
        int     op;
        op = int'(w[6:0]);
        v  = 0;
        case (op)
            'h03, 'h13, 'h67, 'h0F, 'h73: begin
                v = longint'(w[31:20]);
                if (v >= 2048) v = v - 4096;
            end
            'h23: begin
                v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
                if (v >= 2048) v = v - 4096;
            end
            'h63: begin
                v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
                  + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
                if (v >= 4096) v = v - 8192;
            end
            'h37, 'h17: v = longint'(w[31:12]) * 4096;
            'h6F: begin
                v = longint'(w[31]) * (1 << 20) + longint'(w[19:12]) * 4096
                  + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
                if (v >= (1 << 20)) v = v - (1 << 21);
            end
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    function automatic bit ref_known(input logic [6:0] op);
        return op inside {7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63,
                          7'h37, 7'h17, 7'h6F, 7'h33};
    endfunction

    // {out_valid, opcode, rd, funct3, rs1, rs2, funct7, imm, illegal}
    function automatic logic [65:0] ref_out(input logic [31:0] w, input logic v);
        return {v, w[6:0], w[11:7], w[14:12], w[19:15], w[24:20], w[31:25],
                ref_imm(w), v & ~ref_known(w[6:0])};
    endfunction

    function automatic logic [65:0] dut_out();
        return {out_valid, opcode, rd, funct3, rs1, rs2, funct7, imm, illegal};
    endfunction

    task automatic apply(input logic [31:0] w, input logic v);
        @(negedge clk);
        inst     = w;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [65:0] got;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply($urandom, 1'b1);
            got = dut_out();
            checks++;
            if (got !== 66'd0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=0", i, got);
            end
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release out_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] words [5];
        logic [31:0] imms  [5];
        logic [65:0] got, exp;
        words = '{32'hFFC1A283, 32'hFE51AE23, 32'hFE51CF63, 32'h123450B7, 32'hFFDFF06F};
        imms  = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFF7FE, 32'h12345000, 32'hFFFFFFFC};
        for (int i = 0; i < 5; i++) begin
            apply(words[i], 1'b1);
            checks++;
            if (imm !== imms[i]) begin
                errors++;
                $display("FAIL directed_imm inst=%h got=%h exp=%h", words[i], imm, imms[i]);
            end
            got = dut_out();
            exp = ref_out(words[i], 1'b1);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL directed_fields inst=%h got=%h exp=%h", words[i], got, exp);
            end
        end
        // sw: rd slot carries imm[4:0]=28, funct7 carries 0x7F
        apply(32'hFE51AE23, 1'b1);
        checks++;
        if (rd !== 5'd28 || funct7 !== 7'h7F || rs1 !== 5'd3 || rs2 !== 5'd5) begin
            errors++;
            $display("FAIL store_slices rd=%0d f7=%h rs1=%0d rs2=%0d exp=28/7f/3/5",
                     rd, funct7, rs1, rs2);
        end
    endtask

    task automatic test_invalid();
        apply(32'h0000007F, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || illegal !== 1'b0 || opcode !== 7'h7F) begin
            errors++;
            $display("FAIL invalid_flags v=%b ill=%b op=%h exp=0/0/7f", out_valid, illegal, opcode);
        end
        apply(32'hFFC1A283, 1'b0);
        checks++;
        if (imm !== 32'hFFFFFFFC || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL invalid_imm imm=%h v=%b exp=fffffffc/0", imm, out_valid);
        end
    endtask

    task automatic test_illegal_reset();
        logic [65:0] got, exp;
        apply(32'h0000007F, 1'b1);
        checks++;
        if (illegal !== 1'b1 || imm !== 32'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL illegal ill=%b imm=%h v=%b exp=1/0/1", illegal, imm, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        got = dut_out();
        checks++;
        if (got !== 66'd0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0", got);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        inst     = 32'h123450B7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        got = dut_out();
        exp = ref_out(32'h123450B7, 1'b1);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_release_capture got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [11];
        logic [31:0] w;
        logic        v;
        logic [65:0] got, exp;
        ops = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 10)];
            v = 1'($urandom_range(0, 1));
            apply(w, v);
            got = dut_out();
            exp = ref_out(w, v);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random inst=%h v=%b got=%h exp=%h", w, v, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_invalid();
        test_illegal_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
